// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared constants and types for the two-port ALU arbiter.
//   WIDTH  - default operand/result width
//   OP_*   - ALU operation encodings (forwarded unchecked to the ALU)
//   state_t - arbiter FSM states
package alu_ctrl_pkg;

   localparam int WIDTH = 32;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin grant.
//   req[1:0]   in   request lines
//   pri_ptr    in   favoured port when both request
//   enable     in   grants are suppressed when low
//   grant[1:0] out  one-hot grant (or 00)
// The pointer itself is owned by the caller.
module rr_arbiter2
   import alu_ctrl_pkg::*;
(
   input  logic [1:0] req,
   input  logic       pri_ptr,
   input  logic       enable,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (enable) begin
         if (req == 2'b11) grant = pri_ptr ? 2'b10 : 2'b01;
         else              grant = req;  // lone requester wins regardless of pointer
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready[1:0]    per-port request handshake
//   req_a*/req_b*/req_op*       per-port operands and opcode
//   resp_valid/resp_ready[1:0]  per-port response handshake
//   resp_result, resp_zero      captured ALU outputs for the owning port
//   alu_a, alu_b, alu_op        to the shared ALU (held until the next grant)
//   alu_result, alu_zero        from the shared ALU
// Flow: IDLE (grant + latch) -> EXEC (ALU sees latched operands, capture) ->
// RESP (hold until the owner accepts). One transaction in flight.
module alu_arbiter
   import alu_ctrl_pkg::*;
#(
   parameter int WIDTH = alu_ctrl_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_b0,
   input  logic [2:0]       req_op0,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b1,
   input  logic [2:0]       req_op1,
   output logic [1:0]       resp_valid,
   input  logic [1:0]       resp_ready,
   output logic [WIDTH-1:0] resp_result,
   output logic             resp_zero,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero
);

   state_t           state;
   logic             pri_ptr;
   logic             owner;
   logic [WIDTH-1:0] a_q, b_q;
   logic [2:0]       op_q;
   logic [1:0]       grant;

   rr_arbiter2 u_arb (
      .req     (req_valid),
      .pri_ptr (pri_ptr),
      .enable  (state == IDLE),
      .grant   (grant)
   );

   assign req_ready  = grant;
   assign resp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;

   // ALU inputs come straight from the operand registers, so they stay put
   // through EXEC and RESP and only move on the next grant.
   assign alu_a  = a_q;
   assign alu_b  = b_q;
   assign alu_op = op_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pri_ptr     <= 1'b0;
         owner       <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= 3'b000;
         resp_result <= '0;
         resp_zero   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|grant) begin
                  owner   <= grant[1];
                  pri_ptr <= ~grant[1];  // favour the port that just lost
                  a_q     <= grant[1] ? req_a1  : req_a0;
                  b_q     <= grant[1] ? req_b1  : req_b0;
                  op_q    <= grant[1] ? req_op1 : req_op0;
                  state   <= EXEC;
               end
            end
            EXEC: begin
               resp_result <= alu_result;
               resp_zero   <= alu_zero;
               state       <= RESP;
            end
            RESP: begin
               // Only the owner's ready counts; the other port is ignored.
               if (resp_ready[owner]) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
   import alu_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
   logic [31:0] req_a0, req_b0, req_a1, req_b1;
   logic [2:0]  req_op0, req_op1;
   logic [31:0] resp_result, alu_a, alu_b, alu_result;
   logic        resp_zero, alu_zero;
   logic [2:0]  alu_op;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
      .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_result(resp_result), .resp_zero(resp_zero),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_zero(alu_zero)
   );

   // External ALU stand-in; unused codes return XOR so pass-through is visible.
   always_comb begin
      case (alu_op)
         OP_AND:  alu_result = alu_a & alu_b;
         OP_OR:   alu_result = alu_a | alu_b;
         OP_ADD:  alu_result = alu_a + alu_b;
         OP_SUB:  alu_result = alu_a - alu_b;
         OP_SLT:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
         default: alu_result = alu_a ^ alu_b;
      endcase
      alu_zero = (alu_result == 32'd0);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive_port(input int p, input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] op);
      if (p == 0) begin req_a0 = a; req_b0 = b; req_op0 = op; end
      else        begin req_a1 = a; req_b1 = b; req_op1 = op; end
      req_valid[p] = 1'b1;
   endtask

   typedef struct {
      int          port;
      logic [31:0] a, b;
      logic [2:0]  op;
      logic [31:0] exp_res;
      logic        exp_zero;
   } vec_t;

   // One full transaction: request, EXEC check, RESP check, accept.
   task automatic run_vec(input vec_t v);
      logic [1:0] own;
      own = (v.port == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      drive_port(v.port, v.a, v.b, v.op);
      #1 chk("req_ready_grant", {30'd0, req_ready}, {30'd0, own});
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      chk("exec_alu_a", alu_a, v.a);
      chk("exec_alu_b", alu_b, v.b);
      chk("exec_alu_op", {29'd0, alu_op}, {29'd0, v.op});
      chk("exec_resp_valid", {30'd0, resp_valid}, 32'd0);
      @(negedge clk);
      #1;
      chk("resp_valid", {30'd0, resp_valid}, {30'd0, own});
      chk("resp_result", resp_result, v.exp_res);
      chk("resp_zero", {31'd0, resp_zero}, {31'd0, v.exp_zero});
      resp_ready = own;
      @(negedge clk);
      resp_ready = 2'b00;
      #1 chk("resp_valid_after_accept", {30'd0, resp_valid}, 32'd0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   vec_t vecs[9];

   initial begin
      rst_n = 1'b0; req_valid = 2'b00; resp_ready = 2'b00;
      req_a0 = '0; req_b0 = '0; req_op0 = '0;
      req_a1 = '0; req_b1 = '0; req_op1 = '0;

      vecs[0] = '{0, 32'd5,        32'd3, OP_ADD, 32'd8,          1'b0};
      vecs[1] = '{1, 32'd7,        32'd7, OP_SUB, 32'd0,          1'b1};
      vecs[2] = '{0, 32'hF0,       32'h0F, OP_AND, 32'd0,         1'b1};
      vecs[3] = '{1, 32'hF0,       32'h0F, OP_OR,  32'hFF,        1'b0};
      vecs[4] = '{0, 32'd1,        32'd2, OP_SLT, 32'd1,          1'b0};
      vecs[5] = '{1, 32'd2,        32'd1, OP_SLT, 32'd0,          1'b1};
      vecs[6] = '{0, 32'hFFFFFFFF, 32'd1, OP_ADD, 32'd0,          1'b1};
      vecs[7] = '{1, 32'd3,        32'd5, OP_SUB, 32'hFFFFFFFE,   1'b0};
      vecs[8] = '{0, 32'd6,        32'd3, 3'b011, 32'd5,          1'b0};

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
      chk("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
      chk("rst_resp_result", resp_result, 32'd0);
      chk("rst_resp_zero", {31'd0, resp_zero}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
      rst_n = 1'b1;

      // resp_ready high while idle must not produce anything
      @(negedge clk);
      resp_ready = 2'b11;
      @(negedge clk);
      #1 chk("idle_resp_ready_ignored", {30'd0, resp_valid}, 32'd0);
      resp_ready = 2'b00;

      // Request withdrawn before grant is impossible in IDLE (grant is same
      // cycle), so table vectors follow directly.
      foreach (vecs[i]) run_vec(vecs[i]);

      // Contention: both requesting every cycle, pointer from reset.
      pulse_reset();
      @(negedge clk);
      drive_port(0, 32'd1, 32'd2, OP_SLT);
      drive_port(1, 32'hF0, 32'h0F, OP_AND);
      resp_ready = 2'b11;
      for (int k = 0; k < 3; k++) begin
         logic [1:0] own;
         own = (k % 2 == 0) ? 2'b01 : 2'b10;
         #1 chk("cont_grant", {30'd0, req_ready}, {30'd0, own});
         @(negedge clk);
         #1 chk("cont_busy_ready", {30'd0, req_ready}, 32'd0);
         @(negedge clk);
         #1;
         chk("cont_resp_valid", {30'd0, resp_valid}, {30'd0, own});
         chk("cont_result", resp_result, (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("cont_zero", {31'd0, resp_zero}, (k % 2 == 0) ? 32'd0 : 32'd1);
         @(negedge clk);
      end
      req_valid = 2'b00; resp_ready = 2'b00;

      // Backpressure with a waiting request on the other port.
      pulse_reset();
      @(negedge clk);
      drive_port(0, 32'd5, 32'd3, OP_ADD);
      #1 chk("bp_grant0", {30'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      drive_port(1, 32'd1, 32'd2, OP_OR);
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("bp_resp_valid", {30'd0, resp_valid}, 32'd1);
         chk("bp_result", resp_result, 32'd8);
         chk("bp_req_ready", {30'd0, req_ready}, 32'd0);
         @(negedge clk);
      end
      resp_ready = 2'b10;  // non-owner ready: ignored
      @(negedge clk);
      #1 chk("bp_nonowner_ignored", {30'd0, resp_valid}, 32'd1);
      resp_ready = 2'b01;
      @(negedge clk);
      resp_ready = 2'b00;
      #1 chk("bp_waiting_granted", {30'd0, req_ready}, 32'd2);
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      #1;
      chk("bp_resp1_valid", {30'd0, resp_valid}, 32'd2);
      chk("bp_resp1_result", resp_result, 32'd3);
      resp_ready = 2'b10;
      @(negedge clk);
      resp_ready = 2'b00;

      // Reset during EXEC. Port 0 grant would move pointer to 1.
      @(negedge clk);
      drive_port(0, 32'd9, 32'd4, OP_ADD);
      @(negedge clk);
      req_valid = 2'b00;
      #1 chk("mid_exec_alu_a", alu_a, 32'd9);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_alu_a", alu_a, 32'd0);
      chk("mid_rst_alu_op", {29'd0, alu_op}, 32'd0);
      chk("mid_rst_resp_valid", {30'd0, resp_valid}, 32'd0);
      chk("mid_rst_req_ready", {30'd0, req_ready}, 32'd0);
      chk("mid_rst_result", resp_result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1 chk("post_rst_no_resp", {30'd0, resp_valid}, 32'd0);
      end
      drive_port(0, 32'd1, 32'd1, OP_ADD);
      drive_port(1, 32'd2, 32'd2, OP_ADD);
      #1 chk("post_rst_grant_port0", {30'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      #1 chk("post_rst_result", resp_result, 32'd2);
      resp_ready = 2'b01;
      @(negedge clk);
      resp_ready = 2'b00;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
